// File: rtl/snn_pe_scheduler.sv
// Control for one spiking PE: loads a 5x5 filter, streams binary windows
// through the MAC, integrates results into membranes and emits spikes.
module snn_pe_scheduler #(
  parameter int FILTER_WIDTH  = 8,
  parameter int OUTPUT_WIDTH  = 13,
  parameter int MEM_WIDTH     = 16,
  parameter int NUM_WINDOWS   = 4,
  parameter int NUM_TIMESTEPS = 3,
  parameter int THRESHOLD     = 64,
  localparam int WW = (NUM_WINDOWS > 1) ? $clog2(NUM_WINDOWS) : 1,
  localparam int TW = (NUM_TIMESTEPS > 1) ? $clog2(NUM_TIMESTEPS) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      filt_valid,
  output logic                      filt_ready,
  input  logic [5*FILTER_WIDTH-1:0] filt_row,
  input  logic                      ifmap_valid,
  output logic                      ifmap_ready,
  input  logic [24:0]               ifmap_data,
  output logic                      mac_req,
  input  logic                      mac_ack,
  output logic [25*FILTER_WIDTH-1:0] mac_filter,
  output logic [24:0]               mac_ifmap,
  input  logic                      mac_res_valid,
  input  logic [OUTPUT_WIDTH-1:0]   mac_res,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      out_spike,
  output logic [MEM_WIDTH-1:0]      out_mem,
  output logic [WW-1:0]             out_win,
  output logic [TW-1:0]             out_t,
  output logic                      done,
  output logic                      err
);

  localparam int RW = 5 * FILTER_WIDTH;
  localparam int SW =
    ((MEM_WIDTH > OUTPUT_WIDTH) ? MEM_WIDTH : OUTPUT_WIDTH) + 1;
  localparam logic [SW-1:0] MEM_MAX =
    {{(SW-MEM_WIDTH){1'b0}}, {MEM_WIDTH{1'b1}}};
  localparam logic [SW-1:0] THR = SW'(THRESHOLD);
  localparam logic [WW-1:0] WIN_LAST = WW'(NUM_WINDOWS - 1);
  localparam logic [TW-1:0] T_LAST = TW'(NUM_TIMESTEPS - 1);

  typedef enum logic [2:0] {
    S_LOAD,
    S_WAIT_IFMAP,
    S_ISSUE,
    S_WAIT_RES,
    S_UPDATE,
    S_EMIT
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [2:0]              row_q;
  logic [WW-1:0]           win_q;
  logic [TW-1:0]           t_q;
  logic [MEM_WIDTH-1:0]    mem_q [NUM_WINDOWS];
  logic [25*FILTER_WIDTH-1:0] filt_q;
  logic [OUTPUT_WIDTH-1:0] res_q;

  logic [SW-1:0]        sum;
  logic [SW-1:0]        sat;
  logic [MEM_WIDTH-1:0] mem_nx;
  logic                 fire;

  logic filt_go;
  logic ifmap_go;
  logic mac_go;
  logic res_go;
  logic out_go;
  logic last_win;
  logic last_t;

  assign filt_go  = filt_valid & filt_ready;
  assign ifmap_go = ifmap_valid & ifmap_ready;
  assign mac_go   = mac_req & mac_ack;
  assign res_go   = mac_res_valid & (state_q == S_WAIT_RES);
  assign out_go   = out_valid & out_ready;
  assign last_win = (win_q == WIN_LAST);
  assign last_t   = (t_q == T_LAST);

  assign mac_filter = filt_q;

  // Saturating integrate, then subtract-on-fire reset of the membrane.
  always_comb begin
    sum  = SW'(mem_q[win_q]) + SW'(res_q);
    sat  = (sum > MEM_MAX) ? MEM_MAX : sum;
    fire = (sat >= THR);
    mem_nx = fire ? MEM_WIDTH'(sat - THR) : MEM_WIDTH'(sat);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_LOAD;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_LOAD:
        if (filt_go && row_q == 3'd4) state_d = S_WAIT_IFMAP;
      S_WAIT_IFMAP:
        if (ifmap_go) state_d = S_ISSUE;
      S_ISSUE:
        if (mac_go) state_d = S_WAIT_RES;
      S_WAIT_RES:
        if (res_go) state_d = S_UPDATE;
      S_UPDATE:
        state_d = S_EMIT;
      S_EMIT:
        if (out_go)
          state_d = (last_win && last_t) ? S_LOAD : S_WAIT_IFMAP;
      default:
        state_d = S_LOAD;
    endcase
  end

  always_comb begin
    filt_ready  = (state_q == S_LOAD);
    ifmap_ready = (state_q == S_WAIT_IFMAP);
    mac_req     = (state_q == S_ISSUE);
    out_valid   = (state_q == S_EMIT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_q     <= '0;
      win_q     <= '0;
      t_q       <= '0;
      filt_q    <= '0;
      mac_ifmap <= '0;
      res_q     <= '0;
      out_spike <= 1'b0;
      out_mem   <= '0;
      out_win   <= '0;
      out_t     <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
      for (int i = 0; i < NUM_WINDOWS; i++) mem_q[i] <= '0;
    end else begin
      done <= 1'b0;
      if (mac_res_valid && state_q != S_WAIT_RES) err <= 1'b1;
      if (filt_go) begin
        filt_q[row_q*RW +: RW] <= filt_row;
        row_q <= (row_q == 3'd4) ? 3'd0 : row_q + 3'd1;
      end
      if (ifmap_go) mac_ifmap <= ifmap_data;
      if (res_go) res_q <= mac_res;
      if (state_q == S_UPDATE) begin
        mem_q[win_q] <= mem_nx;
        out_spike    <= fire;
        out_mem      <= mem_nx;
        out_win      <= win_q;
        out_t        <= t_q;
      end
      if (out_go) begin
        if (!last_win) begin
          win_q <= win_q + WW'(1);
        end else begin
          win_q <= '0;
          if (!last_t) begin
            t_q <= t_q + TW'(1);
          end else begin
            t_q  <= '0;
            done <= 1'b1;
            for (int i = 0; i < NUM_WINDOWS; i++) mem_q[i] <= '0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_snn_pe_scheduler.sv
// Bench for snn_pe_scheduler: directed steps with random data and delays,
// checked against a per-window membrane model using plain arithmetic.
module tb_snn_pe_scheduler;

  localparam int FW  = 8;
  localparam int OW  = 13;
  localparam int MW  = 8;
  localparam int NW  = 4;
  localparam int NT  = 3;
  localparam int THR = 64;
  localparam int MAXM = 255;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          filt_valid = 1'b0;
  logic          filt_ready;
  logic [39:0]   filt_row = '0;
  logic          ifmap_valid = 1'b0;
  logic          ifmap_ready;
  logic [24:0]   ifmap_data = '0;
  logic          mac_req;
  logic          mac_ack = 1'b0;
  logic [199:0]  mac_filter;
  logic [24:0]   mac_ifmap;
  logic          mac_res_valid = 1'b0;
  logic [OW-1:0] mac_res = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic          out_spike;
  logic [MW-1:0] out_mem;
  logic [1:0]    out_win;
  logic [1:0]    out_t;
  logic          done;
  logic          err;

  int vectors = 0;
  int miscompares = 0;
  int model_mem [NW];
  logic [199:0] exp_f = '0;

  snn_pe_scheduler #(
    .FILTER_WIDTH(FW), .OUTPUT_WIDTH(OW), .MEM_WIDTH(MW),
    .NUM_WINDOWS(NW), .NUM_TIMESTEPS(NT), .THRESHOLD(THR)
  ) dut (
    .clk(clk), .rst(rst),
    .filt_valid(filt_valid), .filt_ready(filt_ready), .filt_row(filt_row),
    .ifmap_valid(ifmap_valid), .ifmap_ready(ifmap_ready),
    .ifmap_data(ifmap_data),
    .mac_req(mac_req), .mac_ack(mac_ack), .mac_filter(mac_filter),
    .mac_ifmap(mac_ifmap), .mac_res_valid(mac_res_valid), .mac_res(mac_res),
    .out_valid(out_valid), .out_ready(out_ready), .out_spike(out_spike),
    .out_mem(out_mem), .out_win(out_win), .out_t(out_t),
    .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [199:0] obs,
                     input logic [199:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < NW; i++) model_mem[i] = 0;
  endtask

  task automatic load_filter(input bit ones);
    logic [39:0] row;
    int n;
    for (int r = 0; r < 5; r++) begin
      n = 0;
      while (!filt_ready && n < 20) begin tick(); n++; end
      chk("filt_ready", filt_ready, 1);
      row = ones ? {5{8'h01}} : {$urandom, $urandom};
      exp_f[r*40 +: 40] = row;
      filt_row = row;
      filt_valid = 1'b1;
      tick();
    end
    filt_valid = 1'b0;
    chk("filt_done_ready", filt_ready, 0);
    chk("filt_to_ifmap", ifmap_ready, 1);
    chk("mac_filter", mac_filter, exp_f);
  endtask

  task automatic do_window(input int w, input int t, input logic [24:0] data,
                           input int res, input int ack_dly, input int hold,
                           input bit abort);
    int n, s;
    bit esp;
    bit last;
    logic sv_spk;
    logic [MW-1:0] sv_mem;
    logic [1:0] sv_w, sv_t;
    last = (w == NW - 1) && (t == NT - 1);
    n = 0;
    while (!ifmap_ready && n < 20) begin tick(); n++; end
    chk("ifmap_ready", ifmap_ready, 1);
    ifmap_data = data;
    ifmap_valid = 1'b1;
    tick();
    ifmap_valid = 1'b0;
    chk("mac_ifmap", mac_ifmap, data);
    chk("mac_req_rise", mac_req, 1);
    chk("filter_stable", mac_filter, exp_f);
    repeat (ack_dly) tick();
    chk("mac_req_held", mac_req, 1);
    mac_ack = 1'b1;
    tick();
    mac_ack = 1'b0;
    chk("mac_req_drop", mac_req, 0);
    if (abort) return;
    repeat ($urandom_range(0, 2)) tick();
    mac_res = OW'(res);
    mac_res_valid = 1'b1;
    tick();
    mac_res_valid = 1'b0;
    chk("out_valid_early", out_valid, 0);
    tick();
    chk("out_valid", out_valid, 1);
    s = model_mem[w] + res;
    if (s > MAXM) s = MAXM;
    esp = (s >= THR);
    model_mem[w] = esp ? s - THR : s;
    chk($sformatf("spike_w%0d_t%0d", w, t), out_spike, esp);
    chk($sformatf("mem_w%0d_t%0d", w, t), out_mem, model_mem[w]);
    chk("out_win", out_win, w);
    chk("out_t", out_t, t);
    sv_spk = out_spike; sv_mem = out_mem; sv_w = out_win; sv_t = out_t;
    for (int h = 0; h < hold; h++) begin
      tick();
      chk("hold_valid", out_valid, 1);
      chk("hold_data", {sv_spk, sv_mem, sv_w, sv_t},
          {out_spike, out_mem, out_win, out_t});
      chk("hold_no_ifmap", ifmap_ready, 0);
      chk("hold_no_req", mac_req, 0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("out_valid_drop", out_valid, 0);
    chk("done", done, last);
    if (last) begin
      clear_model();
      chk("pass_to_load", filt_ready, 1);
      tick();
      chk("done_one_cycle", done, 0);
    end
  endtask

  task automatic do_reset(input bit chk_filter);
    rst = 1'b1;
    ifmap_valid = 1'b0; filt_valid = 1'b0; mac_ack = 1'b0;
    mac_res_valid = 1'b0; out_ready = 1'b0;
    tick();
    chk("rst_filt_ready", filt_ready, 1);
    chk("rst_ifmap_ready", ifmap_ready, 0);
    chk("rst_mac_req", mac_req, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_out_regs", {out_spike, out_mem, out_win, out_t}, 0);
    chk("rst_mac_ifmap", mac_ifmap, 0);
    if (chk_filter) chk("rst_mac_filter", mac_filter, 0);
    rst = 1'b0;
    exp_f = '0;
    clear_model();
    tick();
  endtask

  initial begin
    int res;
    int hold;
    tick();
    do_reset(1'b1);

    // stray result strobe during filter load
    mac_res_valid = 1'b1;
    tick();
    mac_res_valid = 1'b0;
    chk("err_set", err, 1);
    chk("err_state_kept", filt_ready, 1);
    load_filter(1'b1);
    chk("err_sticky", err, 1);

    // ack with no request must be ignored
    mac_ack = 1'b1;
    tick();
    mac_ack = 1'b0;
    chk("stray_ack_req", mac_req, 0);
    chk("stray_ack_state", ifmap_ready, 1);

    // partial pass: all-ones filter, result 25, abort mid-result at w2,t1
    for (int t = 0; t < 2; t++)
      for (int w = 0; w < NW; w++) begin
        if (t == 1 && w == 2) break;
        do_window(w, t, 25'h1FFFFFF, 25, 0, 0, 1'b0);
      end
    do_window(2, 1, 25'h1FFFFFF, 25, 1, 0, 1'b1);
    do_reset(1'b1);

    // pass B: first window result 10 after reset
    load_filter(1'b0);
    for (int t = 0; t < NT; t++)
      for (int w = 0; w < NW; w++) begin
        res = (t == 0 && w == 0) ? 10 : int'($urandom_range(0, 120));
        do_window(w, t, 25'($urandom), res, $urandom_range(0, 3),
                  $urandom_range(0, 1), 1'b0);
      end

    // pass C: saturation, threshold crossings, long output stall
    load_filter(1'b0);
    for (int t = 0; t < NT; t++)
      for (int w = 0; w < NW; w++) begin
        case (w)
          1: res = 200;
          2: res = 25;
          default:
            res = ($urandom_range(0, 3) == 0) ? 8191
                                              : int'($urandom_range(0, 255));
        endcase
        hold = (w == 3 && t == 1) ? 5 : int'($urandom_range(0, 2));
        do_window(w, t, 25'($urandom), res, $urandom_range(0, 3),
                  hold, 1'b0);
      end

    // next pass starts from cleared membranes
    load_filter(1'b0);
    do_window(0, 0, 25'($urandom), 30, 0, 0, 1'b0);
    chk("err_clear_after_rst", err, 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
